// File: rtl/btn_debounce.sv
// Push-button debouncer: a free-running prescaler produces a tick strobe, a two-flop
// synchronizer tames btn_in, and a four-state FSM accepts a level after DB_TICKS stable ticks.
module btn_debounce #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_FREQ = 1000,
   parameter int DB_TICKS  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic tick,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int DIV    = CLK_FREQ / TICK_FREQ;
   localparam int PCNT_W = $clog2(DIV);
   localparam int DCNT_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DB_TICKS - 1);

   typedef enum logic [1:0] {
      LOW,
      WAIT_HIGH,
      HIGH,
      WAIT_LOW
   } state_t;

   logic [PCNT_W-1:0] pcnt;
   logic [DCNT_W-1:0] dcnt;
   logic              sync_meta;
   logic              sync;
   state_t            state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (pcnt == PCNT_MAX);
         pcnt <= (pcnt == PCNT_MAX) ? '0 : pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= btn_in;
         sync      <= sync_meta;
      end
   end

   // A bounce is checked before the tick, so a tick landing on a bounce never counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LOW;
         dcnt        <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         case (state)
            LOW: begin
               if (sync) begin
                  state <= WAIT_HIGH;
                  dcnt  <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!sync) begin
                  state <= LOW;
               end else if (tick) begin
                  if (dcnt == DCNT_MAX) begin
                     state     <= HIGH;
                     btn_level <= 1'b1;
                     btn_press <= 1'b1;
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
            end
            HIGH: begin
               if (!sync) begin
                  state <= WAIT_LOW;
                  dcnt  <= '0;
               end
            end
            WAIT_LOW: begin
               if (sync) begin
                  state <= HIGH;
               end else if (tick) begin
                  if (dcnt == DCNT_MAX) begin
                     state       <= LOW;
                     btn_level   <= 1'b0;
                     btn_release <= 1'b1;
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
            end
            default: state <= LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DIV=10, DB_TICKS=3); pulses are matched against a
// scoreboard of predicted edge numbers counted from rst release.
module tb_btn_debounce;

   localparam int DIV = 10;
   localparam int DB  = 3;

   typedef struct {
      int   cyc;
      logic press;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic tick, btn_level, btn_press, btn_release;

   int  checks = 0;
   int  errors = 0;
   int  cyc;
   ev_t sb[$];

   btn_debounce #(.CLK_FREQ(100), .TICK_FREQ(10), .DB_TICKS(DB)) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .tick(tick),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   // Rising edges since the last rst release.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // btn_in changed after edge m: sync is 1 from edge m+2, the FSM sees it at m+3, ticks are
   // sampled on edges 10k+1, and the DB-th tick after entering the wait is accepted.
   function automatic int predict(input int m);
      int n;
      n = m + 4;
      while ((n % DIV) != 1 || n < DIV + 1) n++;
      return n + (DB - 1) * DIV;
   endfunction

   task automatic wait_level(input logic v, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (btn_level === v) begin
            at = cyc;
            break;
         end
      end
   endtask

   always @(posedge clk) begin
      ev_t e;
      #1;
      if (!rst && (btn_press || btn_release)) begin
         if (sb.size() == 0) begin
            check("pulse_unexpected", {30'd0, btn_press, btn_release}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_kind", {30'd0, btn_press, btn_release}, e.press ? 32'd2 : 32'd1);
            check("pulse_level", {31'd0, btn_level}, {31'd0, e.press});
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int at;
      int exp_at;

      // Reset state.
      step(3);
      check("reset_outs", {28'd0, tick, btn_level, btn_press, btn_release}, 32'd0);
      rst = 1'b0;

      // Idle: ticks on edges 10, 20, 30 only; no button activity.
      for (int n = 1; n <= 35; n++) begin
         step(1);
         check("tick_phase", {31'd0, tick}, {31'd0, (n % DIV) == 0});
         check("idle_outs", {29'd0, btn_level, btn_press, btn_release}, 32'd0);
      end

      // Clean press.
      m = cyc;
      btn_in = 1'b1;
      exp_at = predict(m);
      sb.push_back('{exp_at, 1'b1});
      wait_level(1'b1, 60, at);
      check("press_cycle", at, exp_at);
      check("press_delay", {31'd0, (at - (m + 3)) >= 21 && (at - (m + 3)) <= 30}, 32'd1);
      step(15);
      check("press_hold", {31'd0, btn_level}, 32'd1);

      // Clean release.
      m = cyc;
      btn_in = 1'b0;
      exp_at = predict(m);
      sb.push_back('{exp_at, 1'b0});
      wait_level(1'b0, 60, at);
      check("release_cycle", at, exp_at);
      check("release_delay", {31'd0, (at - (m + 3)) >= 21 && (at - (m + 3)) <= 30}, 32'd1);

      // Bouncing input toggling every 7 cycles must never be accepted.
      for (int i = 0; i < 100; i++) begin
         if (i % 7 == 0) btn_in = ~btn_in;
         step(1);
         check("bounce_level", {31'd0, btn_level}, 32'd0);
      end
      btn_in = 1'b0;
      step(30);
      check("bounce_settled", {31'd0, btn_level}, 32'd0);

      // Press, then reset in the middle of the release wait: no release pulse.
      m = cyc;
      btn_in = 1'b1;
      exp_at = predict(m);
      sb.push_back('{exp_at, 1'b1});
      wait_level(1'b1, 60, at);
      check("press2_cycle", at, exp_at);
      btn_in = 1'b0;
      step(8);
      check("wait_low_level", {31'd0, btn_level}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_reset_outs", {28'd0, tick, btn_level, btn_press, btn_release}, 32'd0);
      step(2);
      rst = 1'b0;
      step(50);
      check("post_reset_low", {31'd0, btn_level}, 32'd0);

      // Reset released with the button already held counts as a fresh press.
      rst = 1'b1;
      btn_in = 1'b1;
      step(2);
      rst = 1'b0;
      exp_at = predict(0);
      sb.push_back('{exp_at, 1'b1});
      wait_level(1'b1, 60, at);
      check("held_reset_press", at, exp_at);
      m = cyc;
      btn_in = 1'b0;
      exp_at = predict(m);
      sb.push_back('{exp_at, 1'b0});
      wait_level(1'b0, 60, at);
      check("held_reset_release", at, exp_at);

      // sync falls on the edge the accepting tick rises: the wait aborts, nothing counts.
      m = cyc;
      btn_in = 1'b1;
      exp_at = predict(m);
      step(exp_at - 3 - m);
      btn_in = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         check("tick_bounce_level", {31'd0, btn_level}, 32'd0);
      end
      m = cyc;
      btn_in = 1'b1;
      exp_at = predict(m);
      sb.push_back('{exp_at, 1'b1});
      wait_level(1'b1, 60, at);
      check("repress_cycle", at, exp_at);

      step(5);
      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter TICK_FREQ, default 1000, meaning the tick strobe frequency in Hz.
REQ-003 The block SHALL have parameter DB_TICKS, default 10, meaning the number of ticks the input must stay stable before a level change is accepted.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port btn_in, input, 1 bit: raw button level, asynchronous to clk, active-high.
REQ-007 The block SHALL have port tick, output, 1 bit: one-clk-wide strobe at TICK_FREQ, for downstream tick-driven counters.
REQ-008 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-009 The block SHALL have port btn_press, output, 1 bit: one-clk pulse on each debounced 0->1 transition.
REQ-010 The block SHALL have port btn_release, output, 1 bit: one-clk pulse on each debounced 1->0 transition.

Function
REQ-011 DIV = CLK_FREQ/TICK_FREQ (integer division) SHALL be >= 2, and DB_TICKS SHALL be >= 1; other values are unsupported.
REQ-012 Prescaler: a counter SHALL run 0..DIV-1 and wrap to 0; every counter width SHALL be sized to hold its maximum value without overflow.
REQ-013 tick SHALL be registered and high for exactly one cycle every DIV cycles; the first assertion comes after exactly DIV rising edges following rst release.
REQ-014 btn_in SHALL pass through a two-flop synchronizer (sync); a btn_in change becomes visible on sync after 2 rising edges.
REQ-015 The debounce FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW, with a tick counter dcnt.
REQ-016 LOW: sync=1 SHALL go to WAIT_HIGH with dcnt=0; otherwise the FSM stays in LOW.
REQ-017 WAIT_HIGH: sync=0 SHALL return to LOW with no output pulse; on tick with sync=1, dcnt SHALL increment; when tick arrives with dcnt=DB_TICKS-1 and sync=1, the FSM SHALL go to HIGH.
REQ-018 HIGH and WAIT_LOW SHALL mirror REQ-016/REQ-017 with sync polarity inverted; the accepting tick moves the FSM to LOW.
REQ-019 If sync and tick change on the same edge, sync SHALL take priority: a bounce on a tick edge aborts the wait and does not count.
REQ-020 The accepted debounce delay SHALL lie between (DB_TICKS-1)*DIV+1 and DB_TICKS*DIV cycles after sync settles.
REQ-021 btn_level SHALL be registered, equal to 1 exactly in HIGH and WAIT_LOW, and change on the edge the FSM enters HIGH or LOW.
REQ-022 btn_press and btn_release SHALL be registered and asserted for exactly one cycle, coincident with the first cycle btn_level shows its new value.
REQ-023 btn_press and btn_release SHALL never be high in the same cycle.
REQ-024 The prescaler SHALL free-run, independent of btn_in and FSM state.

Reset
REQ-025 While rst=1, the following SHALL hold: tick=0, btn_level=0, btn_press=0, btn_release=0, prescaler=0, synchronizer flops=0, dcnt=0, state=LOW.
REQ-026 rst asserted mid-wait or in HIGH SHALL abort immediately, with no btn_release pulse generated.
REQ-027 After rst release with btn_in already 1, the block SHALL treat the input as a new press and debounce it per REQ-017.

Verification (bench parameters: CLK_FREQ=100, TICK_FREQ=10 so DIV=10, DB_TICKS=3)
REQ-028 Release rst, btn_in=0 -> tick high on edges 10, 20, 30; btn_level, btn_press and btn_release stay 0.
REQ-029 btn_in 0->1 held -> btn_level=1 with a single btn_press pulse, 21..30 cycles after sync=1; btn_release stays 0.
REQ-030 btn_in toggled every 7 cycles for 100 cycles, then held 0 -> btn_level, btn_press and btn_release stay 0 throughout.
REQ-031 Stable press, then btn_in 1->0 held -> single btn_release pulse, btn_level=0 within 21..30 cycles of sync=0.
REQ-032 rst pulsed while in WAIT_LOW -> all outputs 0 immediately, no pulse; with btn_in=0 after release, the FSM stays in LOW.
REQ-033 btn_in falls on the same edge as a tick during WAIT_HIGH -> the FSM returns to LOW, and dcnt is not incremented.
